sdram_responder: RTL and testbench

//   Cycle-based SDRAM device model: the responder end of the DE10-Lite SDRAM command bus.

---
 rtl/sdram_responder.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: cycle-based SDRAM device model for the DE10-Lite command bus.
// Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and the ACTIVE-to-access
// delay, stores data in an on-chip array, returns read data after the CAS latency with
// per-lane DQM masking, and latches the first protocol violation.
//   clock, reset_n          : rising-edge clock, async active-low reset
//   dram_addr/ba            : row (ACTIVE) or {A10 auto-precharge, A9:A0 column}; bank
//   dram_cs_n/ras_n/cas_n/we_n : command bits
//   dram_ldqm/udqm          : byte-lane masks for dq[7:0] / dq[15:8]
//   dram_dq                 : bidirectional data, Hi-Z outside the read drive window
//   error_clear             : clears the sticky error state
//   bank_active             : open-row flag per bank
//   error, error_code       : sticky violation flag and code of the first violation
module sdram_responder #(
  parameter int unsigned CAS_LATENCY = 2,
  parameter int unsigned RD_HOLD     = 3,
  parameter int unsigned TRCD        = 3,
  parameter int unsigned MEM_AW      = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [12:0] dram_addr,
  input  logic [1:0]  dram_ba,
  input  logic        dram_cs_n,
  input  logic        dram_ras_n,
  input  logic        dram_cas_n,
  input  logic        dram_we_n,
  input  logic        dram_ldqm,
  input  logic        dram_udqm,
  inout  wire  [15:0] dram_dq,
  input  logic        error_clear,
  output logic [3:0]  bank_active,
  output logic        error,
  output logic [2:0]  error_code
);

  localparam int unsigned TCW   = (TRCD < 1) ? 1 : $clog2(TRCD + 1);
  localparam int unsigned HCW   = $clog2(RD_HOLD + 1);
  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic {B_IDLE, B_OPEN} bank_state_e;

  typedef struct packed {
    logic        valid;
    logic [1:0]  en;    // [1] upper lane, [0] lower lane
    logic [15:0] data;
  } rd_entry_t;

  bank_state_e        state_q [4];
  bank_state_e        state_d [4];
  logic [12:0]        row_q   [4];
  logic [12:0]        row_d   [4];
  logic [TCW-1:0]     trcd_q  [4];
  logic [TCW-1:0]     trcd_d  [4];
  logic [3:0]         ap_q, ap_d;

  logic [1:0]         drv_en_q;
  logic [15:0]        drv_data_q;
  logic [HCW-1:0]     hold_q;

  logic [15:0]        mem [DEPTH];

  logic               is_act_c, is_rd_c, is_wr_c, is_pre_c, is_ref_lmr_c;
  logic               sel_open_c, sel_ready_c;
  logic [2:0]         err_c;
  logic               act_ok_c, rd_ok_c, wr_ok_c;
  logic [MEM_AW-1:0]  idx_c;
  rd_entry_t          rd_new_c, tap_c;

  // Command decode; deselect forces every flag low
  always_comb begin
    is_act_c     = 1'b0;
    is_rd_c      = 1'b0;
    is_wr_c      = 1'b0;
    is_pre_c     = 1'b0;
    is_ref_lmr_c = 1'b0;
    if (!dram_cs_n) begin
      unique case ({dram_ras_n, dram_cas_n, dram_we_n})
        3'b011:         is_act_c     = 1'b1;
        3'b101:         is_rd_c      = 1'b1;
        3'b100:         is_wr_c      = 1'b1;
        3'b010:         is_pre_c     = 1'b1;
        3'b001, 3'b000: is_ref_lmr_c = 1'b1;
        default:        ;
      endcase
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_active
    assign bank_active[b] = (state_q[b] == B_OPEN);
  end

  assign sel_open_c  = (state_q[dram_ba] == B_OPEN);
  assign sel_ready_c = (trcd_q[dram_ba] == TCW'(TRCD));
  assign idx_c       = MEM_AW'({dram_ba, row_q[dram_ba], dram_addr[9:0]});

  // Violation classification; a flagged command has no effect at all
  always_comb begin
    err_c = 3'd0;
    if (is_rd_c || is_wr_c) begin
      if (!sel_open_c)               err_c = 3'd1;
      else if (!sel_ready_c)         err_c = 3'd3;
      else if (is_wr_c && |drv_en_q) err_c = 3'd5;
    end else if (is_act_c && sel_open_c) begin
      err_c = 3'd2;
    end else if (is_ref_lmr_c && |bank_active) begin
      err_c = 3'd4;
    end
  end

  assign act_ok_c = is_act_c && (err_c == 3'd0);
  assign rd_ok_c  = is_rd_c  && (err_c == 3'd0);
  assign wr_ok_c  = is_wr_c  && (err_c == 3'd0);

  // Per-bank next state: auto-precharge closes the bank one edge after the access
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ap_d    = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      trcd_d[b] = trcd_q[b];
      if (state_q[b] == B_OPEN && trcd_q[b] != TCW'(TRCD))
        trcd_d[b] = trcd_q[b] + TCW'(1);
      if (ap_q[b])
        state_d[b] = B_IDLE;
      if (act_ok_c && dram_ba == 2'(b)) begin
        state_d[b] = B_OPEN;
        row_d[b]   = dram_addr;
        trcd_d[b]  = '0;
      end
      if (is_pre_c && (dram_addr[10] || dram_ba == 2'(b)))
        state_d[b] = B_IDLE;
      if ((rd_ok_c || wr_ok_c) && dram_addr[10] && dram_ba == 2'(b))
        ap_d[b] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 4; b++) begin
        state_q[b] <= B_IDLE;
        row_q[b]   <= '0;
        trcd_q[b]  <= '0;
      end
      ap_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      trcd_q  <= trcd_d;
      ap_q    <= ap_d;
    end
  end

  // Sticky error: first violation wins; a violation also beats a same-edge clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error      <= 1'b0;
      error_code <= 3'd0;
    end else if (err_c != 3'd0 && (!error || error_clear)) begin
      error      <= 1'b1;
      error_code <= err_c;
    end else if (error_clear) begin
      error      <= 1'b0;
      error_code <= 3'd0;
    end
  end

  // Backing store, not reset
  always_ff @(posedge clock) begin
    if (wr_ok_c) begin
      if (!dram_ldqm) mem[idx_c][7:0]  <= dram_dq[7:0];
      if (!dram_udqm) mem[idx_c][15:8] <= dram_dq[15:8];
    end
  end

  assign rd_new_c = '{valid: rd_ok_c, en: ~{dram_udqm, dram_ldqm}, data: mem[idx_c]};

  // Latency pipeline: entry reaches the tap on edge E0+CAS_LATENCY-1
  if (CAS_LATENCY <= 1) begin : g_cl1
    assign tap_c = rd_new_c;
  end else begin : g_cln
    rd_entry_t pipe_q [CAS_LATENCY-1];
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(CAS_LATENCY) - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= rd_new_c;
        for (int i = 1; i < int'(CAS_LATENCY) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign tap_c = pipe_q[CAS_LATENCY-2];
  end

  // Drive window: a newer read reloads data and restarts the hold count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drv_en_q   <= 2'b00;
      drv_data_q <= 16'h0000;
      hold_q     <= '0;
    end else if (tap_c.valid) begin
      drv_en_q   <= tap_c.en;
      drv_data_q <= tap_c.data;
      hold_q     <= HCW'(RD_HOLD - 1);
    end else if (hold_q != '0) begin
      hold_q     <= hold_q - HCW'(1);
    end else begin
      drv_en_q   <= 2'b00;
    end
  end

  assign dram_dq[7:0]  = drv_en_q[0] ? drv_data_q[7:0]  : 8'hzz;
  assign dram_dq[15:8] = drv_en_q[1] ? drv_data_q[15:8] : 8'hzz;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder (CAS_LATENCY=2, RD_HOLD=3, TRCD=3).
// Inputs change on the falling edge; registered outputs are read on the falling edge
// after a command edge, and the dq value seen there is what the next rising edge samples.
module tb_sdram_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [12:0] dram_addr;
  logic [1:0]  dram_ba;
  logic        dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic        dram_ldqm, dram_udqm;
  wire  [15:0] dram_dq;
  logic        error_clear;
  logic [3:0]  bank_active;
  logic        error;
  logic [2:0]  error_code;

  logic        tb_oe;
  logic [15:0] tb_dq;
  int          checks = 0;
  int          errors = 0;

  assign dram_dq = tb_oe ? tb_dq : 16'hzzzz;

  always #5 clock = ~clock;

  sdram_responder #(.CAS_LATENCY(2), .RD_HOLD(3), .TRCD(3), .MEM_AW(12)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .dram_addr   (dram_addr),
    .dram_ba     (dram_ba),
    .dram_cs_n   (dram_cs_n),
    .dram_ras_n  (dram_ras_n),
    .dram_cas_n  (dram_cas_n),
    .dram_we_n   (dram_we_n),
    .dram_ldqm   (dram_ldqm),
    .dram_udqm   (dram_udqm),
    .dram_dq     (dram_dq),
    .error_clear (error_clear),
    .bank_active (bank_active),
    .error       (error),
    .error_code  (error_code)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command on the next rising edge; returns on the following falling edge
  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] dqm, input logic oe, input logic [15:0] d);
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = c;
    dram_ba = ba;
    dram_addr = a;
    {dram_udqm, dram_ldqm} = dqm;
    tb_oe = oe;
    tb_dq = d;
    @(posedge clock);
    @(negedge clock);
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = C_NOP;
    {dram_udqm, dram_ldqm} = 2'b00;
    tb_oe = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) cmd(C_NOP, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0000);
  endtask

  initial begin
    reset_n = 1'b0;
    error_clear = 1'b0;
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = C_NOP;
    dram_ba = 2'd0;
    dram_addr = 13'd0;
    {dram_udqm, dram_ldqm} = 2'b00;
    tb_oe = 1'b0;
    tb_dq = 16'h0000;
    repeat (2) @(negedge clock);
    chk("rst_bank_active", 16'(bank_active), 16'h0);
    chk("rst_error", 16'(error), 16'h0);
    chk("rst_error_code", 16'(error_code), 16'h0);
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL rst_dq: observed %h expected zzzz", dram_dq);
    end
    reset_n = 1'b1;

    // 1: write with auto-precharge
    cmd(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
    chk("t1_act", 16'(bank_active), 16'h1);
    nop(4);
    cmd(C_WR, 2'd0, 13'h407, 2'b00, 1'b1, 16'hBEEF);
    chk("t1_open_at_e0", 16'(bank_active), 16'h1);
    nop(1);
    chk("t1_closed_e1", 16'(bank_active), 16'h0);
    chk("t1_no_error", 16'(error), 16'h0);

    // 2: read with auto-precharge, drive window
    cmd(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
    nop(4);
    cmd(C_RD, 2'd0, 13'h407, 2'b00, 1'b0, 16'h0);
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL t2_dq_e1: observed %h expected zzzz", dram_dq);
    end
    nop(1);
    chk("t2_ap_closed", 16'(bank_active), 16'h0);
    chk("t2_dq_e2", dram_dq, 16'hBEEF);
    nop(1);
    chk("t2_dq_e3", dram_dq, 16'hBEEF);
    nop(1);
    chk("t2_dq_e4", dram_dq, 16'hBEEF);
    nop(1);
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL t2_dq_e5: observed %h expected zzzz", dram_dq);
    end

    // 3: masked write then masked read
    cmd(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
    nop(4);
    cmd(C_WR, 2'd0, 13'd7, 2'b10, 1'b1, 16'h1234);
    cmd(C_RD, 2'd0, 13'd7, 2'b01, 1'b0, 16'h0);
    nop(1);
    checks++;
    assert (dram_dq === 16'hBEzz) else begin
      errors++; $error("FAIL t3_dq_lanes: observed %h expected BEzz", dram_dq);
    end
    nop(3);
    cmd(C_PRE, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
    chk("t3_pre", 16'(bank_active), 16'h0);
    chk("t3_no_error", 16'(error), 16'h0);

    // 4: access before TRCD, then sticky code
    cmd(C_ACT, 2'd2, 13'd9, 2'b00, 1'b0, 16'h0);
    nop(1);
    cmd(C_RD, 2'd2, 13'd3, 2'b00, 1'b0, 16'h0);
    chk("t4_error", 16'(error), 16'h1);
    chk("t4_code_trcd", 16'(error_code), 16'h3);
    nop(1);
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL t4_no_drive: observed %h expected zzzz", dram_dq);
    end
    cmd(C_WR, 2'd1, 13'd3, 2'b00, 1'b1, 16'h5555);
    chk("t4_code_sticky", 16'(error_code), 16'h3);
    error_clear = 1'b1;
    nop(1);
    error_clear = 1'b0;
    chk("t4_clear_err", 16'(error), 16'h0);
    chk("t4_clear_code", 16'(error_code), 16'h0);

    // 5: refresh with open banks, precharge all
    cmd(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
    cmd(C_ACT, 2'd3, 13'd1, 2'b00, 1'b0, 16'h0);
    chk("t5_banks", 16'(bank_active), 16'hD);
    cmd(C_REF, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
    chk("t5_code_ref", 16'(error_code), 16'h4);
    chk("t5_banks_kept", 16'(bank_active), 16'hD);
    cmd(C_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
    chk("t5_pre_all", 16'(bank_active), 16'h0);
    error_clear = 1'b1;
    nop(1);
    error_clear = 1'b0;
    cmd(C_REF, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
    cmd(C_LMR, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
    chk("t5_ref_idle_ok", 16'(error), 16'h0);

    // Violation and clear on the same edge
    cmd(C_ACT, 2'd1, 13'd2, 2'b00, 1'b0, 16'h0);
    cmd(C_WR, 2'd2, 13'd0, 2'b00, 1'b1, 16'h7777);
    chk("tc_code_idle", 16'(error_code), 16'h1);
    error_clear = 1'b1;
    cmd(C_ACT, 2'd1, 13'd2, 2'b00, 1'b0, 16'h0);
    error_clear = 1'b0;
    chk("tc_err_wins", 16'(error), 16'h1);
    chk("tc_code_act", 16'(error_code), 16'h2);

    // WRITE while read data is on the bus
    error_clear = 1'b1;
    nop(1);
    error_clear = 1'b0;
    cmd(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
    nop(4);
    cmd(C_RD, 2'd0, 13'd7, 2'b00, 1'b0, 16'h0);
    nop(1);
    cmd(C_WR, 2'd0, 13'd7, 2'b00, 1'b1, 16'h0000);
    chk("t5w_code_busy", 16'(error_code), 16'h5);
    nop(3);

    // 6: reset in the middle of a read window
    cmd(C_RD, 2'd0, 13'd7, 2'b00, 1'b0, 16'h0);
    nop(1);
    chk("t6_banks", 16'(bank_active), 16'h3);
    chk("t6_dq_pre_reset", dram_dq, 16'hBE34);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL t6_dq_reset: observed %h expected zzzz", dram_dq);
    end
    chk("t6_banks_reset", 16'(bank_active), 16'h0);
    chk("t6_error_reset", 16'(error), 16'h0);
    chk("t6_code_reset", 16'(error_code), 16'h0);
    repeat (2) @(negedge clock);
    checks++;
    assert (dram_dq === 16'hzzzz) else begin
      errors++; $error("FAIL t6_dq_held: observed %h expected zzzz", dram_dq);
    end
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
